// File: rtl/scp_boot_loader.sv
// -----------------------------------------------------------------------------
// scp_boot_loader
//
// Boot sequencer for the single-cycle RISC-V core (SCP). It keeps the core in
// reset while a little-endian byte stream is loaded into instruction memory.
// The stream is a 32-bit word count N followed by N instruction words. After
// the last word is written, the core is released. The block then counts run
// cycles until the core's PC sits on the host-supplied halt address for two
// consecutive edges.
//
// Ports
//   clk         system clock, rising-edge
//   reset       asynchronous, active-high
//   rx_data     program byte stream
//   rx_valid    rx_data valid
//   rx_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe (one cycle per word)
//   imem_addr   instruction-memory word address
//   imem_wdata  instruction word to write
//   cpu_reset   reset to the SCP core (active-high)
//   cpu_pc      core PC
//   halt_pc     PC value treated as halt (self-loop address)
//   loaded      high while in RUN
//   halted      sticky halt flag
//   err         sticky header-error flag
//   run_cycles  cycles spent in RUN before halt (saturating)
// -----------------------------------------------------------------------------
module scp_boot_loader #(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   input  logic [31:0]       cpu_pc,
   input  logic [31:0]       halt_pc,
   output logic              loaded,
   output logic              halted,
   output logic              err,
   output logic [31:0]       run_cycles
);

   typedef enum logic [2:0] {
      S_HDR   = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_RUN   = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t              r_state;
   logic [1:0]          r_byte_cnt;
   logic [ADDR_W-1:0]   r_word_cnt;
   logic [ADDR_W-1:0]   r_last;      // N-1, address of the final word
   logic [31:0]         r_shift;     // bytes shift in from the top
   logic                r_halt_seen;
   logic                r_rx_ready;
   logic                r_imem_we;
   logic [ADDR_W-1:0]   r_imem_addr;
   logic [31:0]         r_imem_wdata;
   logic                r_cpu_reset;
   logic                r_loaded;
   logic                r_halted;
   logic                r_err;
   logic [31:0]         r_run_cycles;

   logic                w_accept;
   logic                w_word_done;
   logic [31:0]         w_word;
   logic                w_hdr_bad;
   logic                w_pc_match;

   assign w_accept    = rx_valid && r_rx_ready;
   assign w_word_done = w_accept && (r_byte_cnt == 2'd3);
   // Little-endian: the 4th byte lands on top, earlier bytes have shifted down.
   assign w_word      = {rx_data, r_shift[31:8]};
   assign w_hdr_bad   = (w_word == 32'd0) || (w_word > 32'(DEPTH));
   assign w_pc_match  = (cpu_pc == halt_pc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_HDR;
         r_byte_cnt   <= 2'd0;
         r_word_cnt   <= '0;
         r_last       <= '0;
         r_shift      <= 32'd0;
         r_halt_seen  <= 1'b0;
         r_rx_ready   <= 1'b1;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= 32'd0;
         r_cpu_reset  <= 1'b1;
         r_loaded     <= 1'b0;
         r_halted     <= 1'b0;
         r_err        <= 1'b0;
         r_run_cycles <= 32'd0;
      end else begin
         r_imem_we <= 1'b0;
         if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {rx_data, r_shift[31:8]};
         end
         case (r_state)
            S_HDR: begin
               if (w_word_done) begin
                  if (w_hdr_bad) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state    <= S_LOAD;
                     r_word_cnt <= '0;
                     r_last     <= ADDR_W'(w_word - 32'd1);
                  end
               end
            end
            S_LOAD: begin
               if (w_word_done) begin
                  r_state      <= S_WRITE;
                  r_rx_ready   <= 1'b0;
                  r_imem_we    <= 1'b1;
                  r_imem_addr  <= r_word_cnt;
                  r_imem_wdata <= w_word;
               end
            end
            S_WRITE: begin
               if (r_word_cnt == r_last) begin
                  r_state     <= S_RUN;
                  r_cpu_reset <= 1'b0;
                  r_loaded    <= 1'b1;
               end else begin
                  r_state    <= S_LOAD;
                  r_word_cnt <= r_word_cnt + 1'b1;
                  r_rx_ready <= 1'b1;
               end
            end
            S_RUN: begin
               r_halt_seen <= w_pc_match;
               if (!r_halted) begin
                  if (r_run_cycles != 32'hFFFF_FFFF)
                     r_run_cycles <= r_run_cycles + 32'd1;
                  // Two consecutive matching edges mean the core is parked.
                  if (w_pc_match && r_halt_seen)
                     r_halted <= 1'b1;
               end
            end
            S_ERR: begin
               // Bytes are still accepted and dropped; only reset leaves ERR.
            end
            default: r_state <= S_HDR;
         endcase
      end
   end

   assign rx_ready   = r_rx_ready;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign cpu_reset  = r_cpu_reset;
   assign loaded     = r_loaded;
   assign halted     = r_halted;
   assign err        = r_err;
   assign run_cycles = r_run_cycles;

endmodule

// File: doc/scp_boot_loader.md
Name: scp_boot_loader

Overview:
- Boot sequencer for the single-cycle RISC-V core (SCP).
- Holds the core in reset while a byte stream loads a program image into instruction memory, then releases the core.
- In the run phase, counts execution cycles and detects a halt: the core's PC sitting on a host-supplied halt address.
- Sits between the host/UART byte source, the instruction-memory write port, and the core's reset input.

Parameters:
- ADDR_W, 6, instruction-memory word-address width.
- DEPTH, 64, maximum program length in 32-bit words (must be ≤ 2^ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  program byte stream.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  instruction-memory word address.
- imem_wdata  output  32  instruction word to write.
- cpu_reset  output  1  reset to the SCP core (active-high).
- cpu_pc  input  32  core PC.
- halt_pc  input  32  PC value treated as halt (self-loop address).
- loaded  output  1  high while in RUN.
- halted  output  1  sticky halt flag.
- err  output  1  sticky header-error flag.
- run_cycles  output  32  cycles spent in RUN before halt.

Behaviour:
- Reset is asynchronous. While reset is high: state=HDR, byte_cnt=0, word_cnt=0, shift word=0, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, loaded=0, halted=0, err=0, run_cycles=0, halt_seen=0.
- Reset asserted mid-load or mid-run: the partial word is discarded, cpu_reset returns to 1 immediately, and the load restarts from the header.
- Handshake: a byte is accepted on a rising edge when rx_valid && rx_ready.
- Word assembly: bytes are little-endian; accepted byte k (0..3) goes to word[8k+7:8k]. byte_cnt wraps 3→0.
- States: HDR, LOAD, WRITE, RUN, ERR. All outputs are registered.
- HDR: rx_ready=1. On the 4th accepted byte the assembled word is N.
  - N==0 or N>DEPTH → ERR.
  - Otherwise → LOAD, with word_cnt=0.
- LOAD: rx_ready=1. On the 4th accepted byte → WRITE.
- WRITE: lasts exactly one cycle.
  - imem_we=1, imem_addr=word_cnt, imem_wdata=assembled word, rx_ready=0.
  - If word_cnt==N-1 → RUN; otherwise word_cnt+1 → LOAD.
  - imem_we is 0 in every other state.
- RUN: rx_ready=0, cpu_reset=0, loaded=1 from the first RUN cycle onward.
  - run_cycles=0 in the first RUN cycle; it increments by 1 on each subsequent edge while halted=0, saturating at 0xFFFFFFFF.
  - Halt detection: halt_seen is set on an edge where cpu_pc==halt_pc, and cleared on an edge where they differ.
  - If cpu_pc==halt_pc and halt_seen==1 (two consecutive matching edges), halted←1 and run_cycles freezes.
  - The core is not re-reset on halt. RUN is left only via reset.
- ERR: err=1, cpu_reset=1, rx_ready=1. Bytes are accepted and discarded. No imem writes. Left only via reset.
- rx_valid without rx_ready has no effect. rx_data is ignored when rx_valid=0.
- Latency: a word is written 1 cycle after its 4th byte is accepted. The core is released 1 cycle after the last write.

Test Plan:
- Normal load:
  - Stimulus: reset 20 ns, then bytes 02 00 00 00 | 13 01 50 00 | 93 01 C0 00, rx_valid held high.
  - Response: imem writes addr0=0x00500113, then addr1=0x00C00193, each with a single-cycle imem_we; rx_ready=0 during each write; cpu_reset falls the cycle after the 2nd write; loaded=1.
- Header errors:
  - N=0 (bytes 00 00 00 00) → err=1, cpu_reset=1, no imem_we ever.
  - N=65 (bytes 41 00 00 00, DEPTH=64) → err=1, with subsequent bytes accepted and discarded.
- Gapped stream: N=1 with rx_valid toggled every other cycle → exactly one write of the correct word; no byte lost or duplicated.
- Halt detection:
  - Stimulus: after load, halt_pc=0x24; drive cpu_pc 0,4,8,…,0x24,0x24,0x24.
  - Response: halted rises on the 2nd consecutive 0x24 edge; run_cycles then stays constant. A single-cycle PC match followed by a mismatch does not set halted.
- Reset mid-load: assert reset after 2 bytes of word 1 → outputs return to reset values asynchronously; resending the full image loads correctly from addr0.
- Boundary: N=DEPTH=64 → 64 writes covering addr0..63; RUN entered after the write to addr 63.
